// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared types and constants for the mux4to1 scan sampler
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NUM_SEL = 4;

  localparam logic [6:0] HEX_ZERO = 7'b1000000;

  // Active-low 7-segment patterns, bit order g..a, index = hex digit
  localparam logic [15:0][6:0] SEG_LUT = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    return SEG_LUT[nib];
  endfunction

endpackage

// File: rtl/rate_divider.sv
// rtl/rate_divider.sv - free-running divide-by-DIV tick generator with synchronous clear
module rate_divider #(
  parameter int DIV = 50_000_000
) (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count 0..DIV-1 and wrap; clear pins the count at zero while no scan is stepping
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = !clear && (cnt_q == LAST);

endmodule

// File: rtl/mux_scan_sampler.sv
// rtl/mux_scan_sampler.sv - walks mux4to1 select 0..3, samples Z after settling; SAMPLE_HEX_EN adds 7-seg output
module mux_scan_sampler
  import mux_scan_pkg::*;
#(
  parameter int DIV    = 50_000_000,
  parameter int SETTLE = 2
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic       z_in,
  output logic [1:0] sel,
  output logic       busy,
  output logic [3:0] result,
  output logic       done
`ifdef SAMPLE_HEX_EN
  ,
  output logic [6:0] hex
`endif
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [1:0] SEL_LAST = 2'(NUM_SEL - 1);

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [3:0] shadow_q, shadow_d;
  logic [3:0] result_q, result_d;
  logic       tick;

  rate_divider #(
    .DIV(DIV)
  ) u_rate_divider (
    .CLOCK_50(CLOCK_50),
    .resetn  (resetn),
    .clear   (state_q != STEP),
    .tick    (tick)
  );

  // Next-state: accept start in IDLE, step/sample on ticks, one-cycle DONE
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    settle_d = settle_q;
    shadow_d = shadow_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = STEP;
          sel_d    = 2'd0;
          settle_d = '0;
          shadow_d = 4'd0;
        end
      end
      STEP: begin
        if (tick) begin
          if (settle_q == SETTLE_LAST) begin
            settle_d        = '0;
            shadow_d[sel_q] = z_in;
            if (sel_q == SEL_LAST) begin
              state_d  = DONE;
              // shadow_q[3] is not yet written, so take the live sample directly
              result_d = {z_in, shadow_q[2:0]};
            end else begin
              sel_d = sel_q + 2'd1;
            end
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        sel_d   = 2'd0;
      end
      default: begin
        state_d = IDLE;
        sel_d   = 2'd0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      sel_q    <= 2'd0;
      settle_q <= '0;
      shadow_q <= 4'd0;
      result_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      settle_q <= settle_d;
      shadow_q <= shadow_d;
      result_q <= result_d;
    end
  end

  assign sel    = sel_q;
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;

`ifdef SAMPLE_HEX_EN
  logic [6:0] hex_q;

  // Registered display decode, trails result by one cycle
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      hex_q <= HEX_ZERO;
    end else begin
      hex_q <= hex_decode(result_q);
    end
  end

  assign hex = hex_q;
`endif

endmodule

// File: tb/tb_mux_scan_sampler.sv
// tb/tb_mux_scan_sampler.sv - self-checking bench for mux_scan_sampler
module tb_mux_scan_sampler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, start_b;
  logic       z_a, z_b;
  logic [3:0] data_a;
  logic [1:0] sel_a, sel_b;
  logic       busy_a, busy_b, done_a, done_b;
  logic [3:0] res_a, res_b;
`ifdef SAMPLE_HEX_EN
  logic [6:0] hex_a, hex_b;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // mux4to1 model: Z = {Y,X}[S]
  assign z_a = data_a[sel_a];

  mux_scan_sampler #(.DIV(2), .SETTLE(1)) dut_a (
    .CLOCK_50(clk), .resetn(rst_n), .start(start_a), .z_in(z_a),
    .sel(sel_a), .busy(busy_a), .result(res_a), .done(done_a)
`ifdef SAMPLE_HEX_EN
    , .hex(hex_a)
`endif
  );

  mux_scan_sampler #(.DIV(1), .SETTLE(3)) dut_b (
    .CLOCK_50(clk), .resetn(rst_n), .start(start_b), .z_in(z_b),
    .sel(sel_b), .busy(busy_b), .result(res_b), .done(done_b)
`ifdef SAMPLE_HEX_EN
    , .hex(hex_b)
`endif
  );

  function automatic logic [6:0] seg_ref(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One scan; extra start pulses are raised after cycle p1/p2 (relative to E0)
  task automatic run_scan(input bit which, input logic [3:0] nib, input int p1, input int p2);
    int d, s, l;
    logic [3:0] prev;
    logic [1:0] esel;
    d = which ? 1 : 2;
    s = which ? 3 : 1;
    l = 4 * s * d;
    prev = which ? res_b : res_a;
    if (!which) data_a = nib;
    else z_b = 1'b0;
    if (which) start_b = 1'b1;
    else start_a = 1'b1;
    step();
    start_a = 1'b0;
    start_b = 1'b0;
    for (int n = 0; n <= l + 3; n++) begin
      esel = (n < l) ? 2'(n / (s * d)) : ((n == l) ? 2'd3 : 2'd0);
      check("sel", (which ? sel_b : sel_a), esel);
      check("busy", (which ? busy_b : busy_a), 1'(n <= l));
      check("done", (which ? done_b : done_a), 1'(n == l));
      check("result", (which ? res_b : res_a), ((n < l) ? prev : nib));
`ifdef SAMPLE_HEX_EN
      check("hex", (which ? hex_b : hex_a), seg_ref((n <= l) ? prev : nib));
`endif
      if (which) start_b = (n == p1 || n == p2);
      else start_a = (n == p1 || n == p2);
      if (which) begin
        if (((n + 1) % s == 0) && (n + 1 <= l)) z_b = nib[(n + 1) / s - 1];
        else z_b = ~z_b;
      end
      step();
    end
  endtask

  initial begin
    logic [3:0] nib;
    int pulses;
    bit hit;
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    data_a  = 4'd0;
    z_b     = 1'b0;
    step();
    step();
    check("rst_sel", sel_a, 2'd0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_result", res_a, 4'd0);
    check("rst_result_b", res_b, 4'd0);
`ifdef SAMPLE_HEX_EN
    check("rst_hex", hex_a, 7'b1000000);
`endif
    rst_n = 1'b1;
    step();

    // X=2'b10, Y=2'b01 gives Z per sel 0,1,1,0
    run_scan(1'b0, 4'b0110, -1, -1);

    // Reset in the middle of a scan once sel reaches 2
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 20 && !hit; n++) begin
      if (sel_a == 2'd2) hit = 1'b1;
      else step();
    end
    check("reach_sel2", hit, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_sel", sel_a, 2'd0);
    check("abort_busy", busy_a, 1'b0);
    check("abort_result", res_a, 4'd0);
    check("abort_done", done_a, 1'b0);
    step();
    rst_n = 1'b1;
    for (int n = 0; n < 12; n++) begin
      step();
      check("no_done_after_abort", done_a, 1'b0);
      check("idle_after_abort", busy_a, 1'b0);
    end

    // start held high: back-to-back scans every 10 cycles
    nib = 4'(($urandom() & 32'hF) | 32'h1);
    data_a = nib;
    start_a = 1'b1;
    pulses = 0;
    step();
    for (int n = 0; n < 30; n++) begin
      int m;
      m = n % 10;
      check("held_done", done_a, 1'(m == 8));
      check("held_sel", sel_a, ((m < 8) ? 2'(m / 2) : ((m == 8) ? 2'd3 : 2'd0)));
      if (done_a) begin
        pulses++;
        check("held_result", res_a, nib);
      end
      if (n == 29) start_a = 1'b0;
      step();
    end
    check("held_pulses", pulses, 3);

    // start pulses during STEP and during DONE are ignored
    run_scan(1'b0, 4'($urandom()), 3, 8);

    // Random scans on both configurations
    for (int i = 0; i < 4; i++) run_scan(1'b0, 4'($urandom()), -1, -1);
    for (int i = 0; i < 3; i++) run_scan(1'b1, 4'($urandom()), -1, -1);

    // Display value A
    run_scan(1'b0, 4'hA, -1, -1);
`ifdef SAMPLE_HEX_EN
    check("hex_A", hex_a, 7'b0001000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
